// File: rtl/id_stage.sv
// rtl/id_stage.sv - registered RV32I/RV32E decode stage with valid/ready handshake and load-use stall
module id_stage #(
  parameter int XLEN     = 32,
  parameter bit RV32E    = 1'b0,
  parameter int ALU_OP_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic                out_read_reg1,
  output logic                out_read_reg2,
  output logic                out_write_reg,
  output logic                out_read_mem,
  output logic                out_write_mem,
  output logic [1:0]          out_mem_size,
  output logic                out_mem_unsigned,
  output logic                out_alu_src_imm,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_illegal,
  output logic                hazard_stall
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_SUB   = 5'd2;
  localparam logic [4:0] ALU_SLL   = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SRL   = 5'd5;
  localparam logic [4:0] ALU_OR    = 5'd6;
  localparam logic [4:0] ALU_AND   = 5'd7;
  localparam logic [4:0] ALU_LOAD  = 5'd8;
  localparam logic [4:0] ALU_ADDI  = 5'd9;
  localparam logic [4:0] ALU_STORE = 5'd10;
  localparam logic [4:0] ALU_BEQ   = 5'd11;
  localparam logic [4:0] ALU_BLT   = 5'd12;
  localparam logic [4:0] ALU_BGE   = 5'd13;
  localparam logic [4:0] ALU_JAL   = 5'd14;
  localparam logic [4:0] ALU_SLT   = 5'd15;
  localparam logic [4:0] ALU_SLTU  = 5'd16;
  localparam logic [4:0] ALU_SRA   = 5'd17;
  localparam logic [4:0] ALU_LUI   = 5'd18;
  localparam logic [4:0] ALU_AUIPC = 5'd19;
  localparam logic [4:0] ALU_JALR  = 5'd20;
  localparam logic [4:0] ALU_BNE   = 5'd21;
  localparam logic [4:0] ALU_BLTU  = 5'd22;
  localparam logic [4:0] ALU_BGEU  = 5'd23;

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_sh;

  logic [4:0]      w_op;
  logic            w_r1;
  logic            w_r2;
  logic            w_wr;
  logic            w_rm;
  logic            w_wm;
  logic [1:0]      w_sz;
  logic            w_us;
  logic            w_si;
  logic [XLEN-1:0] w_imm;
  logic            w_ill;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic            w_xfer_in;
  logic            w_xfer_out;

  logic                r_valid;
  logic [XLEN-1:0]     r_pc;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [4:0]          r_rs1;
  logic [4:0]          r_rs2;
  logic [4:0]          r_rd;
  logic                r_read_reg1;
  logic                r_read_reg2;
  logic                r_write_reg;
  logic                r_read_mem;
  logic                r_write_mem;
  logic [1:0]          r_mem_size;
  logic                r_mem_unsigned;
  logic                r_alu_src_imm;
  logic [XLEN-1:0]     r_imm;
  logic                r_illegal;

  assign w_opcode = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];

  assign w_imm_i  = XLEN'($signed(in_inst[31:20]));
  assign w_imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign w_imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign w_imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign w_imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign w_imm_sh = XLEN'(in_inst[24:20]);

  always_comb begin
    w_op  = 5'd0;
    w_r1  = 1'b0;
    w_r2  = 1'b0;
    w_wr  = 1'b0;
    w_rm  = 1'b0;
    w_wm  = 1'b0;
    w_sz  = 2'd0;
    w_us  = 1'b0;
    w_si  = 1'b0;
    w_imm = '0;
    w_ill = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_r1 = 1'b1;
        w_r2 = 1'b1;
        w_wr = 1'b1;
        if (w_f7 == 7'h00) begin
          case (w_f3)
            3'b000:  w_op = ALU_ADD;
            3'b001:  w_op = ALU_SLL;
            3'b010:  w_op = ALU_SLT;
            3'b011:  w_op = ALU_SLTU;
            3'b100:  w_op = ALU_XOR;
            3'b101:  w_op = ALU_SRL;
            3'b110:  w_op = ALU_OR;
            default: w_op = ALU_AND;
          endcase
        end else if (w_f7 == 7'h20 && w_f3 == 3'b000) begin
          w_op = ALU_SUB;
        end else if (w_f7 == 7'h20 && w_f3 == 3'b101) begin
          w_op = ALU_SRA;
        end else begin
          w_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_r1  = 1'b1;
        w_wr  = 1'b1;
        w_si  = 1'b1;
        w_imm = w_imm_i;
        case (w_f3)
          3'b000:  w_op = ALU_ADDI;
          3'b001: begin
            w_op  = ALU_SLL;
            w_imm = w_imm_sh;
          end
          3'b010:  w_op = ALU_SLT;
          3'b011:  w_op = ALU_SLTU;
          3'b100:  w_op = ALU_XOR;
          3'b101: begin
            w_op  = in_inst[30] ? ALU_SRA : ALU_SRL;
            w_imm = w_imm_sh;
          end
          3'b110:  w_op = ALU_OR;
          default: w_op = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        w_r1  = 1'b1;
        w_wr  = 1'b1;
        w_rm  = 1'b1;
        w_si  = 1'b1;
        w_op  = ALU_LOAD;
        w_imm = w_imm_i;
        w_sz  = w_f3[1:0];
        w_us  = w_f3[2];
        w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        w_r1  = 1'b1;
        w_r2  = 1'b1;
        w_wm  = 1'b1;
        w_si  = 1'b1;
        w_op  = ALU_STORE;
        w_imm = w_imm_s;
        w_sz  = w_f3[1:0];
        w_ill = (w_f3 > 3'd2);
      end
      OPC_BRANCH: begin
        w_r1  = 1'b1;
        w_r2  = 1'b1;
        w_imm = w_imm_b;
        case (w_f3)
          3'b000:  w_op = ALU_BEQ;
          3'b001:  w_op = ALU_BNE;
          3'b100:  w_op = ALU_BLT;
          3'b101:  w_op = ALU_BGE;
          3'b110:  w_op = ALU_BLTU;
          3'b111:  w_op = ALU_BGEU;
          default: w_ill = 1'b1;
        endcase
      end
      OPC_JAL: begin
        w_wr  = 1'b1;
        w_si  = 1'b1;
        w_op  = ALU_JAL;
        w_imm = w_imm_j;
      end
      OPC_JALR: begin
        w_r1  = 1'b1;
        w_wr  = 1'b1;
        w_si  = 1'b1;
        w_op  = ALU_JALR;
        w_imm = w_imm_i;
        w_ill = (w_f3 != 3'b000);
      end
      OPC_LUI: begin
        w_wr  = 1'b1;
        w_si  = 1'b1;
        w_op  = ALU_LUI;
        w_imm = w_imm_u;
      end
      OPC_AUIPC: begin
        w_wr  = 1'b1;
        w_si  = 1'b1;
        w_op  = ALU_AUIPC;
        w_imm = w_imm_u;
      end
      default: w_ill = 1'b1;
    endcase
    // RV32E only has x0..x15; any enabled index with bit 4 set is out of range
    if (RV32E && ((w_r1 && in_inst[19]) || (w_r2 && in_inst[24]) || (w_wr && in_inst[11]))) begin
      w_ill = 1'b1;
    end
    if (w_ill) begin
      w_op  = 5'd0;
      w_r1  = 1'b0;
      w_r2  = 1'b0;
      w_wr  = 1'b0;
      w_rm  = 1'b0;
      w_wm  = 1'b0;
      w_sz  = 2'd0;
      w_us  = 1'b0;
      w_si  = 1'b0;
      w_imm = '0;
    end
  end

  assign w_rs1 = w_r1 ? in_inst[19:15] : 5'd0;
  assign w_rs2 = w_r2 ? in_inst[24:20] : 5'd0;
  assign w_rd  = w_wr ? in_inst[11:7]  : 5'd0;

  // Stall only against a valid load in the output register that writes a register we read
  assign hazard_stall = in_valid && r_valid && r_read_mem && (r_rd != 5'd0) &&
                        ((w_r1 && (w_rs1 == r_rd)) || (w_r2 && (w_rs2 == r_rd)));
  assign in_ready     = !flush && !hazard_stall && (!r_valid || out_ready);
  assign w_xfer_in    = in_valid && in_ready;
  assign w_xfer_out   = r_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid        <= 1'b0;
      r_pc           <= '0;
      r_alu_op       <= '0;
      r_rs1          <= 5'd0;
      r_rs2          <= 5'd0;
      r_rd           <= 5'd0;
      r_read_reg1    <= 1'b0;
      r_read_reg2    <= 1'b0;
      r_write_reg    <= 1'b0;
      r_read_mem     <= 1'b0;
      r_write_mem    <= 1'b0;
      r_mem_size     <= 2'd0;
      r_mem_unsigned <= 1'b0;
      r_alu_src_imm  <= 1'b0;
      r_imm          <= '0;
      r_illegal      <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_xfer_in) begin
      r_valid        <= 1'b1;
      r_pc           <= in_pc;
      r_alu_op       <= ALU_OP_W'(w_op);
      r_rs1          <= w_rs1;
      r_rs2          <= w_rs2;
      r_rd           <= w_rd;
      r_read_reg1    <= w_r1;
      r_read_reg2    <= w_r2;
      r_write_reg    <= w_wr;
      r_read_mem     <= w_rm;
      r_write_mem    <= w_wm;
      r_mem_size     <= w_sz;
      r_mem_unsigned <= w_us;
      r_alu_src_imm  <= w_si;
      r_imm          <= w_imm;
      r_illegal      <= w_ill;
    end else if (w_xfer_out) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid        = r_valid;
  assign out_pc           = r_pc;
  assign out_alu_op       = r_alu_op;
  assign out_rs1          = r_rs1;
  assign out_rs2          = r_rs2;
  assign out_rd           = r_rd;
  assign out_read_reg1    = r_read_reg1;
  assign out_read_reg2    = r_read_reg2;
  assign out_write_reg    = r_write_reg;
  assign out_read_mem     = r_read_mem;
  assign out_write_mem    = r_write_mem;
  assign out_mem_size     = r_mem_size;
  assign out_mem_unsigned = r_mem_unsigned;
  assign out_alu_src_imm  = r_alu_src_imm;
  assign out_imm          = r_imm;
  assign out_illegal      = r_illegal;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Registered, handshaked RV32I/RV32E instruction-decode stage for the pipelined core. It sits between the fetch stage and the execute stage. It extends the single-cycle decoder in four ways: a wider opcode set, immediates parametrised to XLEN, a valid/ready pipeline register, and load-use hazard stalling.

Parameters:
XLEN, 32, datapath width; immediates and PC are sign-extended or carried at this width (32 or 64).
RV32E, 0, when 1, any used register index >= 16 decodes as illegal.
ALU_OP_W, 6, width of the alu_op code.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
flush  in  1  kill the output register and refuse input this cycle.
in_valid  in  1  fetch presents an instruction.
in_ready  out  1  stage accepts in_inst/in_pc this cycle.
in_inst  in  32  instruction word.
in_pc  in  XLEN  PC of in_inst.
out_valid  out  1  decoded bundle is valid.
out_ready  in  1  execute consumes the bundle this cycle.
out_pc  out  XLEN  registered PC.
out_alu_op  out  ALU_OP_W  operation code.
out_rs1, out_rs2, out_rd  out  5  register indices; 0 when the field is unused.
out_read_reg1, out_read_reg2, out_write_reg  out  1  register-file enables.
out_read_mem, out_write_mem  out  1  memory enables.
out_mem_size  out  2  0 = byte, 1 = half, 2 = word.
out_mem_unsigned  out  1  LBU/LHU.
out_alu_src_imm  out  1  operand B is out_imm.
out_imm  out  XLEN  sign-extended immediate; 0 when the format has none.
out_illegal  out  1  undecodable instruction.
hazard_stall  out  1  load-use stall active this cycle (combinational).

Behaviour:
- Reset (rst_n = 0 at a clk edge): out_valid = 0 and every out_* register = 0. Reset has priority over flush, which has priority over load.
- alu_op codes: ADD 1, SUB 2, SLL 3, XOR 4, SRL 5, OR 6, AND 7, LOAD 8, ADDI 9, STORE 10, BEQ 11, BLT 12, BGE 13, JAL 14, SLT 15, SLTU 16, SRA 17, LUI 18, AUIPC 19, JALR 20, BNE 21, BLTU 22, BGEU 23.
- OP-IMM instructions reuse the R codes with alu_src_imm = 1; ADDI uses 9.
- Immediate formats:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - U: {inst[31:12], 12'b0}.
  - All are sign-extended from inst[31] to XLEN.
  - SLLI/SRLI/SRAI: the immediate is shamt = inst[24:20], zero-extended.
- Register and memory enables by class:
  - read_reg1: R, I, S, B, JALR.
  - read_reg2: R, S, B.
  - write_reg: R, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR.
  - Each index is forced to 0 when its enable is 0.
- Illegal decode produces out_illegal = 1, alu_op = 0, and all enables = 0. Causes:
  - unknown opcode;
  - R-type funct7 not 0x00/0x20, or 0x20 with a funct3 other than ADD/SRL;
  - branch funct3 010/011;
  - load funct3 011/110/111;
  - store funct3 > 2;
  - JALR funct3 != 0;
  - RV32E = 1 and any used index >= 16.
- Handshake:
  - Latency is 1 cycle from acceptance to out_valid.
  - in_ready = !flush && !hazard_stall && (!out_valid || out_ready).
  - Transfer-in occurs when in_valid && in_ready.
  - Transfer-out occurs when out_valid && out_ready.
  - The output register loads only on transfer-in. Otherwise, on transfer-out it clears out_valid, and if neither occurs it holds.
  - The bundle never changes while out_valid && !out_ready.
- Load-use hazard: hazard_stall = in_valid && out_valid && out_read_mem && out_rd != 0 && ((read_reg1(in) && rs1(in) == out_rd) || (read_reg2(in) && rs2(in) == out_rd)).
  - While stalled, a transfer-out leaves a bubble (out_valid = 0).
  - The stall then drops the next cycle and the instruction is accepted.
- Flush: out_valid = 0 next cycle regardless of out_ready, and nothing is accepted that cycle. A flush coincident with out_ready still counts the current bundle as consumed.
- Simultaneous transfer-in and transfer-out (same cycle): new bundle loads and out_valid stays 1; this is full-throughput back-to-back.

Test Plan:
- Back-to-back with out_ready = 1: ADD x3,x1,x2 (0x002081B3), then ADDI x5,x0,-1 (0xFFF00293). Required: out_alu_op 1 then 9, second bundle out_imm = 0xFFFFFFFF with alu_src_imm = 1, out_valid high on consecutive cycles.
- Load-use: LW x6,0(x1) (0x0000A303), then ADD x7,x6,x6 (0x006303B3). Required: hazard_stall = 1 for one cycle, one bubble cycle with out_valid = 0, then ADD issues.
- Backpressure: hold out_ready = 0 for 3 cycles with LUI x1,0x12345 (0x123450B7). Required: in_ready = 0 throughout and the bundle is stable with out_imm = 0x12345000; the next instruction issues on the cycle after out_ready = 1.
- Flush and reset:
  - Flush while out_valid = 1 and in_valid = 1: out_valid = 0 next cycle and the pending instruction is not accepted.
  - rst_n = 0 mid-stream: all outputs 0 next edge.
- Illegal decode:
  - inst 0xFFFFFFFF: out_illegal = 1 and write_reg = 0.
  - With RV32E = 1, ADD x16,x1,x2 (0x00208833): out_illegal = 1; with RV32E = 0 the same word is legal.
- XLEN = 64: BEQ with offset -4 (0xFE000EE3). Required: out_imm = 0xFFFFFFFFFFFFFFFC and alu_op = 11.
